// File: rtl/audio_pkg.sv
// Shared defaults and engine state encoding for the record, mix and pitch engines.
package audio_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int SLOT_LOG2_DEF  = 2;
  localparam int DEPTH_LOG2_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE,
    ST_PAUSE,
    ST_DONE
  } engine_state_e;

endpackage

// File: rtl/record_engine_write_port.sv
// Single-entry req/ack write port: holds address and data stable until the arbiter acks.
module rec_write_port
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = SLOT_LOG2_DEF + DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              wr_busy,
  output logic              wr_done
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    req_d  = req_q;
    addr_d = addr_q;
    data_d = data_q;
    if (req_q) begin
      if (mem_ack) req_d = 1'b0;
    end else if (wr_start) begin
      req_d  = 1'b1;
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign wr_busy   = req_q;
  assign wr_done   = req_q & mem_ack;

endmodule

// File: rtl/record_engine.sv
// Record engine: captures ADC samples into a selected SRAM slot under control-core handshake.
module record_engine
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SLOT_LOG2  = SLOT_LOG2_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            record_start,
  input  logic [SLOT_LOG2-1:0]            record_select,
  input  logic                            record_pause,
  input  logic                            record_stop,
  output logic                            record_done,
  output logic                            busy,
  output logic [DEPTH_LOG2:0]             rec_length,
  output logic                            overrun,
  input  logic                            adc_valid,
  input  logic [DATA_W-1:0]               adc_data,
  output logic                            mem_req,
  output logic [SLOT_LOG2+DEPTH_LOG2-1:0] mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic                            mem_ack
);

  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int ADDR_W = SLOT_LOG2 + DEPTH_LOG2;

  engine_state_e        state_q, state_d;
  logic [SLOT_LOG2-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     rec_length_q, rec_length_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 overrun_q, overrun_d;

  logic wr_start, wr_busy, wr_done;
  logic slot_full;

  // The write in flight is the last slot entry when the low index bits are all ones.
  assign slot_full = &count_q[DEPTH_LOG2-1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      count_q      <= '0;
      rec_length_q <= '0;
      stop_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
      rec_length_q <= rec_length_d;
      stop_pend_q  <= stop_pend_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    count_d      = count_q;
    rec_length_d = rec_length_q;
    stop_pend_d  = stop_pend_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      ST_IDLE: begin
        if (record_start) begin
          slot_d       = record_select;
          count_d      = '0;
          rec_length_d = '0;
          overrun_d    = 1'b0;
          stop_pend_d  = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (record_stop)       state_d = ST_DONE;
        else if (adc_valid)    state_d = ST_WRITE;
        else if (record_pause) state_d = ST_PAUSE;
      end
      ST_WRITE: begin
        if (adc_valid)   overrun_d   = 1'b1;
        if (record_stop) stop_pend_d = 1'b1;
        if (wr_done) begin
          count_d = count_q + 1'b1;
          // A stop arriving on the ack cycle counts as pending too.
          if (slot_full || stop_pend_q || record_stop) state_d = ST_DONE;
          else if (record_pause)                      state_d = ST_PAUSE;
          else                                        state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (record_stop)        state_d = ST_DONE;
        else if (!record_pause) state_d = ST_RUN;
      end
      ST_DONE: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Load the length on entry so it is already valid during the done pulse.
    if (state_d == ST_DONE && state_q != ST_DONE) rec_length_d = count_d;
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    record_done = (state_q == ST_DONE);
    wr_start    = (state_q == ST_RUN) && !record_stop && adc_valid && !wr_busy;
  end

  assign rec_length = rec_length_q;
  assign overrun    = overrun_q;

  rec_write_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_write_port (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .wr_start  (wr_start),
    .wr_addr   ({slot_q, count_q[DEPTH_LOG2-1:0]}),
    .wr_data   (adc_data),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_busy   (wr_busy),
    .wr_done   (wr_done)
  );

endmodule

// File: tb/tb_record_engine.sv
// Directed bench for record_engine: a full-depth instance and a 16-deep instance share stimulus.
module tb_record_engine;

  localparam int DW = 16;
  localparam int SL = 2;
  localparam int DA = 18;
  localparam int DB = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, pause = 1'b0, stop = 1'b0, adc_valid = 1'b0, ack = 1'b0;
  logic          use_b = 1'b0;
  logic [SL-1:0] sel = '0;
  logic [DW-1:0] adc_data = '0;

  logic start_a, start_b, ack_a, ack_b;
  assign start_a = start & ~use_b;
  assign start_b = start & use_b;
  assign ack_a   = ack & ~use_b;
  assign ack_b   = ack & use_b;

  logic             done_a, busy_a, overrun_a, req_a;
  logic [DA:0]      len_a;
  logic [SL+DA-1:0] addr_a;
  logic [DW-1:0]    wdata_a;
  logic             done_b, busy_b, overrun_b, req_b;
  logic [DB:0]      len_b;
  logic [SL+DB-1:0] addr_b;
  logic [DW-1:0]    wdata_b;

  record_engine #(.DATA_W(DW), .SLOT_LOG2(SL), .DEPTH_LOG2(DA)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n),
    .record_start(start_a), .record_select(sel), .record_pause(pause), .record_stop(stop),
    .record_done(done_a), .busy(busy_a), .rec_length(len_a), .overrun(overrun_a),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .mem_req(req_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_ack(ack_a)
  );

  record_engine #(.DATA_W(DW), .SLOT_LOG2(SL), .DEPTH_LOG2(DB)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n),
    .record_start(start_b), .record_select(sel), .record_pause(pause), .record_stop(stop),
    .record_done(done_b), .busy(busy_b), .rec_length(len_b), .overrun(overrun_b),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .mem_req(req_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_ack(ack_b)
  );

  logic        cur_done, cur_busy, cur_ovr, cur_req;
  logic [31:0] cur_len, cur_addr, cur_data;
  assign cur_done = use_b ? done_b : done_a;
  assign cur_busy = use_b ? busy_b : busy_a;
  assign cur_ovr  = use_b ? overrun_b : overrun_a;
  assign cur_req  = use_b ? req_b : req_a;
  assign cur_len  = use_b ? 32'(len_b) : 32'(len_a);
  assign cur_addr = use_b ? 32'(addr_b) : 32'(addr_a);
  assign cur_data = use_b ? 32'(wdata_b) : 32'(wdata_a);

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_take(input logic [SL-1:0] slot);
    sel   = slot;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [DW-1:0] d);
    exp_q.push_back(wr_t'{addr: a, data: d});
  endtask

  // Pops the next expected write, holds the ack off for `hold` cycles, then acks it.
  task automatic expect_write(input string tag, input int hold, input int stop_at, input int drop_at);
    wr_t e;
    e = '0;
    check({tag, " req_up"}, 32'(cur_req), 32'd1);
    check({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, " addr"}, cur_addr, e.addr);
    check({tag, " data"}, cur_data, 32'(e.data));
    for (int k = 0; k < hold; k++) begin
      if (k == stop_at) stop = 1'b1;
      if (k == drop_at) begin
        adc_valid = 1'b1;
        adc_data  = 16'hDEAD;
      end
      tick();
      stop      = 1'b0;
      adc_valid = 1'b0;
      check({tag, " req_hold"}, 32'(cur_req), 32'd1);
      check({tag, " addr_hold"}, cur_addr, e.addr);
      check({tag, " data_hold"}, cur_data, 32'(e.data));
      check({tag, " no_early_done"}, 32'(cur_done), 32'd0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, " req_drop"}, 32'(cur_req), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst done_a", 32'(done_a), 32'd0);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst len_a", 32'(len_a), 32'd0);
    check("rst overrun_a", 32'(overrun_a), 32'd0);
    check("rst req_a", 32'(req_a), 32'd0);
    check("rst addr_a", 32'(addr_a), 32'd0);
    check("rst req_b", 32'(req_b), 32'd0);
    check("rst busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // Stop in IDLE is ignored
    do_stop();
    check("idle_stop done", 32'(cur_done), 32'd0);
    check("idle_stop busy", 32'(cur_busy), 32'd0);

    // Test 1: slot 2, five samples, ack after two cycles each
    start_take(2'd2);
    check("t1 busy", 32'(cur_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      d = 16'h1000 + 16'(i);
      push(32'h80000 + 32'(i), d);
      send(d);
      expect_write("t1_w", 2, -1, -1);
    end
    do_stop();
    check("t1 done", 32'(cur_done), 32'd1);
    check("t1 len", cur_len, 32'd5);
    tick();
    check("t1 done_once", 32'(cur_done), 32'd0);
    check("t1 busy_off", 32'(cur_busy), 32'd0);
    check("t1 len_held", cur_len, 32'd5);

    // Test 2: overrun during a held request; start while busy is ignored
    start_take(2'd1);
    check("t2 ovr_clear", 32'(cur_ovr), 32'd0);
    start_take(2'd3);
    check("t2 busy", 32'(cur_busy), 32'd1);
    push(32'h40000, 16'hA001);
    send(16'hA001);
    expect_write("t2_w0", 10, -1, 3);
    check("t2 overrun", 32'(cur_ovr), 32'd1);
    push(32'h40001, 16'hA002);
    send(16'hA002);
    expect_write("t2_w1", 1, -1, -1);
    do_stop();
    check("t2 done", 32'(cur_done), 32'd1);
    check("t2 len", cur_len, 32'd2);
    check("t2 ovr_sticky", 32'(cur_ovr), 32'd1);
    tick();

    // Test 3: pause 20 cycles with adc_valid toggling
    start_take(2'd0);
    check("t3 ovr_clear", 32'(cur_ovr), 32'd0);
    push(32'h0, 16'hB000);
    send(16'hB000);
    expect_write("t3_w0", 1, -1, -1);
    pause = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      adc_valid = k[0];
      adc_data  = 16'hBEEF;
      tick();
      check("t3 pause_no_req", 32'(cur_req), 32'd0);
    end
    adc_valid = 1'b0;
    pause     = 1'b0;
    tick();
    check("t3 pause_no_ovr", 32'(cur_ovr), 32'd0);
    push(32'h1, 16'hB001);
    send(16'hB001);
    expect_write("t3_w1", 1, -1, -1);
    check("t3 ovr", 32'(cur_ovr), 32'd0);
    do_stop();
    check("t3 done", 32'(cur_done), 32'd1);
    check("t3 len", cur_len, 32'd2);
    tick();

    // Test 4: stop while a write is pending
    start_take(2'd3);
    push(32'hC0000, 16'hC0DE);
    send(16'hC0DE);
    expect_write("t4_w", 4, 1, -1);
    check("t4 done_after_ack", 32'(cur_done), 32'd1);
    check("t4 len", cur_len, 32'd1);
    tick();
    check("t4 done_once", 32'(cur_done), 32'd0);
    check("t4 busy_off", 32'(cur_busy), 32'd0);

    // Test 5: 16-deep instance, stream 20 samples into slot 2
    use_b = 1'b1;
    start_take(2'd2);
    for (int i = 0; i < 20; i++) begin
      d = 16'h5000 + 16'(i);
      if (i < 16) begin
        push(32'h20 + 32'(i), d);
        send(d);
        expect_write("t5_w", 0, -1, -1);
        if (i == 15) begin
          check("t5 full_done", 32'(cur_done), 32'd1);
          check("t5 full_len", cur_len, 32'd16);
        end else begin
          check("t5 not_done", 32'(cur_done), 32'd0);
        end
      end else begin
        send(d);
        check("t5 no_extra_req", 32'(cur_req), 32'd0);
      end
    end
    check("t5 done_gone", 32'(cur_done), 32'd0);
    check("t5 busy_off", 32'(cur_busy), 32'd0);
    check("t5 len_held", cur_len, 32'd16);
    use_b = 1'b0;

    // Test 6: reset mid-write, then a fresh take begins at index 0
    start_take(2'd1);
    send(16'h6000);
    check("t6 req_up", 32'(cur_req), 32'd1);
    check("t6 addr", cur_addr, 32'h40000);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst_req", 32'(cur_req), 32'd0);
    check("t6 rst_busy", 32'(cur_busy), 32'd0);
    check("t6 rst_done", 32'(cur_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6 no_done", 32'(cur_done), 32'd0);
    end
    start_take(2'd1);
    push(32'h40000, 16'h6001);
    send(16'h6001);
    expect_write("t6_w", 1, -1, -1);
    do_stop();
    check("t6 done", 32'(cur_done), 32'd1);
    check("t6 len", cur_len, 32'd1);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
